out_channel_reader: RTL
=======================

OUT_CHANNEL_READER -- requirements
Module: out_channel_reader

Interface
REQ-001 SHALL have parameter MemoryElementWidth, default 12, the width of one channel word.
REQ-002 SHALL have parameter NExpected, default 16, the number of entries in the expected-value table.
REQ-003 SHALL have parameter Depth, default 8 (a power of two), the number of entries in the receive FIFO.
REQ-004 clock  input  1  the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 inValid  input  1  the producer (program out channel) presents a word.
REQ-007 inData  input  MemoryElementWidth  the word presented.
REQ-008 inReady  output  1  the block accepts inData this cycle.
REQ-009 expWrite  input  1  write expData into the expected table at expIndex.
REQ-010 expIndex  input  log2(NExpected)  expected-table address.
REQ-011 expData  input  MemoryElementWidth  expected value.
REQ-012 expCount  input  log2(NExpected)+1  number of words to check; sampled on start.
REQ-013 start  input  1  one-cycle pulse that begins a check run.
REQ-014 clear  input  1  returns the block to IDLE and empties the FIFO.
REQ-015 outValid / outData / outReady  output / output / input  1 / MemoryElementWidth / 1  host drain port fed from the FIFO.
REQ-016 received  output  log2(NExpected)+1  count of accepted words.
REQ-017 mismatchIndex  output  log2(NExpected)  index of the first mismatching word.
REQ-018 finished, success  output  1 each  run complete, and all words matched.

Function
REQ-019 SHALL implement the states IDLE, RUN, DONE and ERROR.
REQ-020 SHALL take expWrite only in IDLE; the table entry is updated the next cycle, and expWrite is ignored in any other state.
REQ-021 SHALL, on start in IDLE, latch min(expCount, NExpected), zero received, and enter RUN the next cycle; start outside IDLE SHALL be ignored.
REQ-022 SHALL drive inReady = (state==RUN) && FIFO not full, combinationally from registered state only, with no path from inValid.
REQ-023 SHALL, on accept (inValid && inReady), push inData, compare it with expected[received], and increment received, all in the same edge.
REQ-024 SHALL, on a mismatch, set mismatchIndex=received(pre-increment) and enter ERROR; the mismatching word is still pushed into the FIFO.
REQ-025 SHALL enter DONE when the accepted word makes received equal the latched count with no mismatch.
REQ-026 SHALL give mismatch priority over completion when both occur on the same word, leading to ERROR.
REQ-027 SHALL, when the latched count is 0, go IDLE -> RUN -> DONE with no word accepted.
REQ-028 SHALL hold finished=1 in DONE and ERROR, with success=1 only in DONE; both outputs are registered.
REQ-029 SHALL hold inReady=0 in DONE and ERROR, so extra words stall at the producer.
REQ-030 SHALL make the FIFO first-word-fall-through: outValid = not empty, and outData = the head entry.
REQ-031 SHALL pop the FIFO on outValid && outReady in every state.
REQ-032 SHALL block a push when the FIFO is full, even if a pop occurs in the same cycle.
REQ-033 SHALL allow a simultaneous push and pop when the FIFO is not full, leaving the occupancy unchanged.
REQ-034 SHALL wrap the FIFO read and write pointers modulo Depth, and use an occupancy counter 0..Depth.
REQ-035 SHALL make clear take priority over all other inputs: next state IDLE, FIFO emptied, received=0, finished=0, success=0; the expected table is kept.

Reset
REQ-036 SHALL, while reset=0, force state IDLE, FIFO empty, pointers 0, received=0, mismatchIndex=0, finished=0, success=0, inReady=0 and outValid=0.
REQ-037 SHALL, on reset asserted mid-RUN, discard all in-flight state immediately, without waiting for a clock edge.
REQ-038 SHALL leave the expected-table contents undefined after reset, with no reset required on the table.

Verification
REQ-039 Load expected {2}, start with expCount=1, send 2 -> finished=1, success=1, received=1, and outData=2 visible to the host.
REQ-040 Load expected {5,6,7}, send 5,9 -> ERROR, mismatchIndex=1, received=2, inReady=0, and the FIFO holds 5,9.
REQ-041 Hold outReady=0 with Depth=8 and expCount=12, send continuously -> inReady falls after 8 accepts; raise outReady -> all 12 words complete in order, success=1.
REQ-042 Start with expCount=0 -> finished=1 and success=1 two cycles after start; inValid=1 is never accepted.
REQ-043 Pull reset low mid-RUN after 3 words -> outputs are at reset values immediately; after a new load and start, a fresh run passes.
REQ-044 Keep outReady=1 so a push and pop occur in the same cycle over 20 words (NExpected=20) -> occupancy stays at most 1, order is preserved, success=1.

Source files
------------

// File: rtl/out_channel_reader.sv
// Receives words from a program out channel, checks them against a preloaded
// expected-value table, and buffers them in a FWFT FIFO for the host to drain.
module out_channel_reader #(
    parameter int MemoryElementWidth = 12,
    parameter int NExpected          = 16,
    parameter int Depth              = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          inValid,
    input  logic [MemoryElementWidth-1:0] inData,
    output logic                          inReady,
    input  logic                          expWrite,
    input  logic [$clog2(NExpected)-1:0]  expIndex,
    input  logic [MemoryElementWidth-1:0] expData,
    input  logic [$clog2(NExpected):0]    expCount,
    input  logic                          start,
    input  logic                          clear,
    output logic                          outValid,
    output logic [MemoryElementWidth-1:0] outData,
    input  logic                          outReady,
    output logic [$clog2(NExpected):0]    received,
    output logic [$clog2(NExpected)-1:0]  mismatchIndex,
    output logic                          finished,
    output logic                          success
);

    localparam int IW = $clog2(NExpected);
    localparam int CW = IW + 1;
    localparam int PW = $clog2(Depth);
    localparam logic [CW-1:0] NEXP     = CW'(NExpected);
    localparam logic [PW:0]   FULL_OCC = (PW+1)'(Depth);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [1:0] ERROR = 2'd3;

    logic [1:0]                    state;
    logic [CW-1:0]                 count;
    logic [CW-1:0]                 count_sel;
    logic [CW-1:0]                 received_inc;
    logic [MemoryElementWidth-1:0] table_mem [NExpected];
    logic [MemoryElementWidth-1:0] fifo_mem  [Depth];
    logic [PW-1:0]                 wptr;
    logic [PW-1:0]                 rptr;
    logic [PW:0]                   occ;
    logic                          full;
    logic                          push;
    logic                          pop;
    logic                          match;

    // A zero-length run must not accept a word during its single RUN cycle,
    // so readiness also requires words remaining (all registered terms).
    assign full         = (occ == FULL_OCC);
    assign inReady      = (state == RUN) && !full && (received != count);
    assign push         = inValid && inReady && !clear;
    assign pop          = outValid && outReady && !clear;
    assign outValid     = (occ != '0);
    assign outData      = fifo_mem[rptr];
    assign received_inc = received + CW'(1);
    assign match        = (table_mem[received[IW-1:0]] == inData);
    assign count_sel    = (expCount > NEXP) ? NEXP : expCount;

    always_ff @(posedge clock) begin
        if (expWrite && (state == IDLE) && !clear && ({1'b0, expIndex} < NEXP))
            table_mem[expIndex] <= expData;
    end

    always_ff @(posedge clock) begin
        if (push)
            fifo_mem[wptr] <= inData;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else begin
            if (push)
                wptr <= wptr + PW'(1);
            if (pop)
                rptr <= rptr + PW'(1);
            if (push && !pop)
                occ <= occ + (PW+1)'(1);
            else if (!push && pop)
                occ <= occ - (PW+1)'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            count         <= '0;
            received      <= '0;
            mismatchIndex <= '0;
            finished      <= 1'b0;
            success       <= 1'b0;
        end else if (clear) begin
            state    <= IDLE;
            received <= '0;
            finished <= 1'b0;
            success  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count    <= count_sel;
                        received <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (push) begin
                        received <= received_inc;
                        // Mismatch wins over completion on the same word.
                        if (!match) begin
                            mismatchIndex <= received[IW-1:0];
                            state         <= ERROR;
                            finished      <= 1'b1;
                            success       <= 1'b0;
                        end else if (received_inc == count) begin
                            state    <= DONE;
                            finished <= 1'b1;
                            success  <= 1'b1;
                        end
                    end else if (received == count) begin
                        state    <= DONE;
                        finished <= 1'b1;
                        success  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
